// File: rtl/argmax_classifier_if.sv
// Score stream and result bus of the argmax classifier.
// ARGMAX_MARGIN_EN adds the Margin result signal.
interface argmax_classifier_if #(
    parameter int unsigned SCORE_W = 26,
    parameter int unsigned IDX_W   = 4
);
    logic               Start;
    logic               ScoreValid;
    logic [SCORE_W-1:0] Score;
    logic               Busy;
    logic               Done;
    logic [IDX_W-1:0]   ClassIdx;
    logic [SCORE_W-1:0] MaxScore;
    logic               Overrun;
`ifdef ARGMAX_MARGIN_EN
    logic [SCORE_W-1:0] Margin;

    modport master (
        output Start, ScoreValid, Score,
        input  Busy, Done, ClassIdx, MaxScore, Overrun, Margin
    );
    modport slave (
        input  Start, ScoreValid, Score,
        output Busy, Done, ClassIdx, MaxScore, Overrun, Margin
    );
`else
    modport master (
        output Start, ScoreValid, Score,
        input  Busy, Done, ClassIdx, MaxScore, Overrun
    );
    modport slave (
        input  Start, ScoreValid, Score,
        output Busy, Done, ClassIdx, MaxScore, Overrun
    );
`endif
endinterface

// File: rtl/argmax_classifier.sv
// Streaming argmax over NUM_CLASSES signed scores; reports winning class and score.
// ARGMAX_MARGIN_EN adds runner-up tracking and a saturated Margin output.
module argmax_classifier #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned SCORE_W     = 26,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                clk,
    input  logic                GlobalReset,
    argmax_classifier_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]         r_state,   w_state;
    logic [IDX_W-1:0]   r_count,   w_count;
    logic               r_busy,    w_busy;
    logic               r_done,    w_done;
    logic [IDX_W-1:0]   r_idx,     w_idx;
    logic [SCORE_W-1:0] r_max,     w_max;
    logic               r_overrun, w_overrun;
    logic               w_accept;
    logic               w_gt_max;

    assign w_gt_max = $signed(bus.Score) > $signed(r_max);

    // Next-state and result update; Start overrides everything else
    always_comb begin
        w_state   = r_state;
        w_count   = r_count;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_idx     = r_idx;
        w_max     = r_max;
        w_overrun = r_overrun;
        w_accept  = 1'b0;
        if (bus.Start) begin
            w_state   = S_ACCUM;
            w_count   = '0;
            w_busy    = 1'b1;
            w_overrun = 1'b0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (bus.ScoreValid) begin
                        w_accept = 1'b1;
                        if ((r_count == '0) || w_gt_max) begin
                            w_max = bus.Score;
                            w_idx = r_count;
                        end
                        w_count = r_count + IDX_W'(1);
                        if (r_count == LAST_IDX) begin
                            w_state = S_DONE;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    if (bus.ScoreValid) w_overrun = 1'b1;
                end
                default: begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    if (bus.ScoreValid) w_overrun = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_idx     <= '0;
            r_max     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_count   <= w_count;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_idx     <= w_idx;
            r_max     <= w_max;
            r_overrun <= w_overrun;
        end
    end

    assign bus.Busy     = r_busy;
    assign bus.Done     = r_done;
    assign bus.ClassIdx = r_idx;
    assign bus.MaxScore = r_max;
    assign bus.Overrun  = r_overrun;

`ifdef ARGMAX_MARGIN_EN
    localparam logic [SCORE_W-1:0] MARGIN_SAT = {1'b0, {(SCORE_W-1){1'b1}}};

    logic [SCORE_W-1:0] r_second, w_second;
    logic               r_second_vld, w_second_vld;
    logic [SCORE_W-1:0] r_margin, w_margin;
    logic [SCORE_W:0]   w_diff;

    // max >= runner-up, so the extended difference is never negative
    assign w_diff = {w_max[SCORE_W-1], w_max} - {w_second[SCORE_W-1], w_second};

    always_comb begin
        w_second     = r_second;
        w_second_vld = r_second_vld;
        w_margin     = r_margin;
        if (bus.Start) begin
            w_second_vld = 1'b0;
            w_margin     = '0;
        end else if (w_accept) begin
            if (r_count == '0) begin
                w_second_vld = 1'b0;
            end else if (w_gt_max) begin
                w_second     = r_max;
                w_second_vld = 1'b1;
            end else if (!r_second_vld || ($signed(bus.Score) > $signed(r_second))) begin
                w_second     = bus.Score;
                w_second_vld = 1'b1;
            end
            if (w_done) begin
                if (!w_second_vld)          w_margin = '0;
                else if (w_diff[SCORE_W] || w_diff[SCORE_W-1]) w_margin = MARGIN_SAT;
                else                        w_margin = w_diff[SCORE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_second     <= '0;
            r_second_vld <= 1'b0;
            r_margin     <= '0;
        end else begin
            r_second     <= w_second;
            r_second_vld <= w_second_vld;
            r_margin     <= w_margin;
        end
    end

    assign bus.Margin = r_margin;
`else
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Randomized and directed bench for argmax_classifier against a reference model.
module tb_argmax_classifier;
    localparam int unsigned NC = 10;
    localparam int unsigned SW = 26;
    localparam int unsigned IW = 4;
    localparam longint SAT = (longint'(1) << (SW - 1)) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    argmax_classifier_if #(.SCORE_W(SW), .IDX_W(IW)) bus ();

    argmax_classifier #(.NUM_CLASSES(NC), .SCORE_W(SW), .IDX_W(IW)) dut (
        .clk         (clk),
        .GlobalReset (rst_n),
        .bus         (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [IW-1:0] exp_idx = '0;
    logic [SW-1:0] exp_max = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner = first index of the largest value; runner-up = largest of the rest
    function automatic void ref_argmax(input logic [SW-1:0] sc [NC], output logic [IW-1:0] idx,
                                       output logic [SW-1:0] mx, output logic [SW-1:0] mg);
        int     best   = 0;
        longint ru     = 0;
        bit     ru_set = 1'b0;
        longint d;
        for (int i = 1; i < NC; i++)
            if ($signed(sc[i]) > $signed(sc[best])) best = i;
        for (int i = 0; i < NC; i++)
            if (i != best && (!ru_set || longint'($signed(sc[i])) > ru)) begin
                ru     = longint'($signed(sc[i]));
                ru_set = 1'b1;
            end
        d = ru_set ? longint'($signed(sc[best])) - ru : 0;
        if (d > SAT) d = SAT;
        idx = IW'(best);
        mx  = sc[best];
        mg  = SW'(d);
    endfunction

    task automatic run_class(input logic [SW-1:0] sc [NC], input int gap, input bit rand_gap,
                             input bit collide, input bit poke_done, input string tag);
        logic [IW-1:0] e_idx;
        logic [SW-1:0] e_max;
        logic [SW-1:0] e_mg;
        int g;
        ref_argmax(sc, e_idx, e_max, e_mg);
        bus.Start      = 1'b1;
        bus.ScoreValid = collide;
        bus.Score      = SW'($urandom);
        @(posedge clk); #1;
        bus.Start      = 1'b0;
        bus.ScoreValid = 1'b0;
        check({tag, "_busy_start"}, 64'(bus.Busy), 64'd1);
        check({tag, "_done_start"}, 64'(bus.Done), 64'd0);
        check({tag, "_ovr_start"},  64'(bus.Overrun), 64'd0);
        check({tag, "_idx_hold"},   64'(bus.ClassIdx), 64'(exp_idx));
        check({tag, "_max_hold"},   64'(bus.MaxScore), 64'(exp_max));
`ifdef ARGMAX_MARGIN_EN
        check({tag, "_mg_clear"},   64'(bus.Margin), 64'd0);
`endif
        for (int k = 0; k < NC; k++) begin
            g = rand_gap ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                @(posedge clk); #1;
                check({tag, "_busy_stall"}, 64'({bus.Busy, bus.Done}), 64'b10);
            end
            bus.ScoreValid = 1'b1;
            bus.Score      = sc[k];
            @(posedge clk); #1;
            bus.ScoreValid = 1'b0;
            if (k < NC - 1) check({tag, "_busy_acc"}, 64'({bus.Busy, bus.Done}), 64'b10);
        end
        check({tag, "_done"},  64'(bus.Done), 64'd1);
        check({tag, "_busy_done"}, 64'(bus.Busy), 64'd0);
        check({tag, "_idx"},   64'(bus.ClassIdx), 64'(e_idx));
        check({tag, "_max"},   64'(bus.MaxScore), 64'(e_max));
        check({tag, "_ovr"},   64'(bus.Overrun), 64'd0);
`ifdef ARGMAX_MARGIN_EN
        check({tag, "_margin"}, 64'(bus.Margin), 64'(e_mg));
`endif
        exp_idx = e_idx;
        exp_max = e_max;
        if (poke_done) begin
            bus.ScoreValid = 1'b1;
            bus.Score      = SW'($urandom);
        end
        @(posedge clk); #1;
        bus.ScoreValid = 1'b0;
        check({tag, "_done_pulse"}, 64'(bus.Done), 64'd0);
        check({tag, "_idx_after"},  64'(bus.ClassIdx), 64'(exp_idx));
        check({tag, "_max_after"},  64'(bus.MaxScore), 64'(exp_max));
        check({tag, "_ovr_after"},  64'(bus.Overrun), 64'(poke_done));
    endtask

    logic [SW-1:0] sc [NC];
    logic [SW-1:0] pool [4];

    initial begin
        bus.Start      = 1'b0;
        bus.ScoreValid = 1'b0;
        bus.Score      = '0;
        pool[0] = 26'h0080000;
        pool[1] = 26'h3FC0000;
        pool[2] = 26'h1FFFFFF;
        pool[3] = 26'h2000000;
        #1 rst_n = 1'b0;
        #2;
        check("rst_outputs", 64'({bus.Busy, bus.Done, bus.Overrun, bus.ClassIdx, bus.MaxScore}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1: class 7 wins
        for (int k = 0; k < NC; k++) sc[k] = 26'h0040000;
        sc[7] = 26'h0140000;
        run_class(sc, 0, 1'b0, 1'b0, 1'b0, "t1");
        check("t1_idx_const", 64'(bus.ClassIdx), 64'd7);
        check("t1_max_const", 64'(bus.MaxScore), 64'h0140000);

        // Test 2: all equal, lowest index wins
        for (int k = 0; k < NC; k++) sc[k] = 26'h0080000;
        run_class(sc, 0, 1'b0, 1'b0, 1'b0, "t2");
        check("t2_idx_const", 64'(bus.ClassIdx), 64'd0);

        // Test 3: negative scores, signed compare; then Overrun in DONE
        for (int k = 0; k < NC; k++) sc[k] = 26'h3FC0000;
        sc[3] = 26'h3FE0000;
        run_class(sc, 0, 1'b0, 1'b0, 1'b1, "t3");
        check("t3_idx_const", 64'(bus.ClassIdx), 64'd3);

        // Test 4: valid every third cycle
        for (int k = 0; k < NC; k++) sc[k] = 26'h0040000;
        sc[7] = 26'h0140000;
        run_class(sc, 2, 1'b0, 1'b0, 1'b0, "t4");

        // Test 5: reset after 5 scores
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.ScoreValid = 1'b1;
            bus.Score      = SW'($urandom);
            @(posedge clk); #1;
        end
        bus.ScoreValid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_async", 64'({bus.Busy, bus.Done, bus.Overrun, bus.ClassIdx, bus.MaxScore}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_idx = '0;
        exp_max = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check("t5_no_done", 64'({bus.Busy, bus.Done}), 64'd0);
        end
        bus.ScoreValid = 1'b1;
        bus.Score      = 26'h1234567;
        @(posedge clk); #1;
        bus.ScoreValid = 1'b0;
        check("t5_ovr_idle", 64'(bus.Overrun), 64'd1);
        check("t5_max_idle", 64'(bus.MaxScore), 64'd0);
        for (int k = 0; k < NC; k++) sc[k] = SW'($urandom);
        run_class(sc, 0, 1'b0, 1'b0, 1'b0, "t5");

        // Random classifications: mixed full-range and tie-prone values, stalls, collisions
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < NC; k++)
                sc[k] = ($urandom_range(0, 1) == 0) ? SW'($urandom) : pool[$urandom_range(0, 3)];
            run_class(sc, 0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
